// File: rtl/mem_bus_arbiter.sv
// Arbitrates one cyc/stb/ack memory bus between instruction fetch and the MEM-stage data port.
// Data requests win. A bus-busy counter aborts transactions that a slave never acknowledges.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    output logic        stallreq_if_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_sel_i,
    output logic [31:0] d_rdata_o,
    output logic        d_ack_o,
    output logic        stallreq_mem_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_sel_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {StIdle, StIbus, StDbus, StDone} state_e;

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        discard_q;
    logic        bus_cyc_q, bus_stb_q, bus_we_q;
    logic [31:0] bus_addr_q, bus_wdata_q;
    logic [3:0]  bus_sel_q;
    logic [31:0] if_rdata_q, d_rdata_q;
    logic        if_ack_q, d_ack_q, bus_err_q;
    logic        timeout;

    assign timeout = (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            discard_q   <= 1'b0;
            bus_cyc_q   <= 1'b0;
            bus_stb_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            if_ack_q  <= 1'b0;
            d_ack_q   <= 1'b0;
            bus_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (d_req_i) begin
                        state_q     <= StDbus;
                        bus_cyc_q   <= 1'b1;
                        bus_stb_q   <= 1'b1;
                        bus_we_q    <= d_we_i;
                        bus_addr_q  <= d_addr_i;
                        bus_wdata_q <= d_wdata_i;
                        bus_sel_q   <= d_sel_i;
                    end else if (if_req_i) begin
                        state_q    <= StIbus;
                        bus_cyc_q  <= 1'b1;
                        bus_stb_q  <= 1'b1;
                        bus_we_q   <= 1'b0;
                        bus_addr_q <= if_addr_i;
                        bus_sel_q  <= 4'hF;
                    end
                end
                StIbus, StDbus: begin
                    if (state_q == StIbus && flush_i) discard_q <= 1'b1;
                    if (!bus_ack_i) cnt_q <= cnt_q + 8'd1;
                    if (bus_ack_i || timeout) begin
                        state_q   <= StDone;
                        bus_cyc_q <= 1'b0;
                        bus_stb_q <= 1'b0;
                        bus_err_q <= !bus_ack_i;
                        if (state_q == StDbus) begin
                            d_ack_q   <= 1'b1;
                            d_rdata_q <= bus_ack_i ? bus_rdata_i : '0;
                        end else begin
                            // A flush in this very cycle must also suppress the ack.
                            if_ack_q   <= !(discard_q || flush_i);
                            if_rdata_q <= bus_ack_i ? bus_rdata_i : '0;
                        end
                    end
                end
                StDone: begin
                    state_q   <= StIdle;
                    cnt_q     <= '0;
                    discard_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_cyc_o      = bus_cyc_q;
    assign bus_stb_o      = bus_stb_q;
    assign bus_we_o       = bus_we_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_wdata_o    = bus_wdata_q;
    assign bus_sel_o      = bus_sel_q;
    assign bus_err_o      = bus_err_q;
    assign if_rdata_o     = if_rdata_q;
    assign d_rdata_o      = d_rdata_q;
    assign if_ack_o       = if_ack_q;
    assign d_ack_o        = d_ack_q;
    assign stallreq_mem_o = d_req_i & ~d_ack_q;
    assign stallreq_if_o  = if_req_i & ~if_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios, then random transactions against a
// transaction-level model (grant order, strobe count, returned data, error flag).
module tb_mem_bus_arbiter;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_ack_o, stallreq_if_o;
    logic        d_req_i = 1'b0, d_we_i = 1'b0;
    logic [31:0] d_addr_i = '0, d_wdata_i = '0;
    logic [3:0]  d_sel_i = '0;
    logic [31:0] d_rdata_o;
    logic        d_ack_o, stallreq_mem_o;
    logic        bus_cyc_o, bus_stb_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;
    logic        bus_err_o;

    int n_assert = 0;
    int n_fail = 0;

    // Slave: acks in strobe cycle number slv_wait (0-based), junk data otherwise.
    bit          slv_en = 1'b1;
    int          slv_wait = 0;
    int          slv_cnt = 0;
    logic [31:0] slv_data = '0;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] data;
        int          w;
        bit          fl;
    } txn_t;

    txn_t q[$];

    mem_bus_arbiter #(.TIMEOUT(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_rdata_o    (if_rdata_o),
        .if_ack_o      (if_ack_o),
        .stallreq_if_o (stallreq_if_o),
        .d_req_i       (d_req_i),
        .d_we_i        (d_we_i),
        .d_addr_i      (d_addr_i),
        .d_wdata_i     (d_wdata_i),
        .d_sel_i       (d_sel_i),
        .d_rdata_o     (d_rdata_o),
        .d_ack_o       (d_ack_o),
        .stallreq_mem_o(stallreq_mem_o),
        .bus_cyc_o     (bus_cyc_o),
        .bus_stb_o     (bus_stb_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_sel_o     (bus_sel_o),
        .bus_rdata_i   (bus_rdata_i),
        .bus_ack_i     (bus_ack_i),
        .bus_err_o     (bus_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (slv_en) begin
            if (bus_stb_o) begin
                bus_ack_i = (slv_cnt == slv_wait);
                slv_cnt++;
            end else begin
                bus_ack_i = 1'b0;
                slv_cnt   = 0;
            end
            bus_rdata_i = bus_ack_i ? slv_data : ~slv_data;
        end
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cyc"}, 32'(bus_cyc_o), 32'd0);
        chk({tag, "_stb"}, 32'(bus_stb_o), 32'd0);
        chk({tag, "_we"}, 32'(bus_we_o), 32'd0);
        chk({tag, "_addr"}, bus_addr_o, 32'd0);
        chk({tag, "_wdata"}, bus_wdata_o, 32'd0);
        chk({tag, "_sel"}, 32'(bus_sel_o), 32'd0);
        chk({tag, "_acks"}, {29'd0, if_ack_o, d_ack_o, bus_err_o}, 32'd0);
        chk({tag, "_if_rdata"}, if_rdata_o, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata_o, 32'd0);
    endtask

    initial begin
        txn_t t;
        int   kind, n, s, exp_s;
        logic [31:0] exp_rd;

        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b0;

        // 1: zero-wait fetch
        slv_wait = 0; slv_data = 32'h2401_0005;
        if_req_i = 1'b1; if_addr_i = 32'h40;
        #1;
        chk("t1_stall_c0", 32'(stallreq_if_o), 32'd1);
        step();
        chk("t1_addr", bus_addr_o, 32'h40);
        chk("t1_sel", 32'(bus_sel_o), 32'hF);
        chk("t1_we", 32'(bus_we_o), 32'd0);
        chk("t1_stb", 32'(bus_stb_o & bus_cyc_o), 32'd1);
        chk("t1_stall_c1", 32'(stallreq_if_o), 32'd1);
        step();
        chk("t1_ack", 32'(if_ack_o), 32'd1);
        chk("t1_rdata", if_rdata_o, 32'h2401_0005);
        chk("t1_stall_c2", 32'(stallreq_if_o), 32'd0);
        if_req_i = 1'b0;
        step();

        // 2: simultaneous requests, data wins
        slv_wait = 0; slv_data = 32'hA5A5_5A5A;
        if_req_i = 1'b1; if_addr_i = 32'h44;
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF;
        d_sel_i = 4'b0011;
        step();
        chk("t2_we", 32'(bus_we_o), 32'd1);
        chk("t2_sel", 32'(bus_sel_o), 32'h3);
        chk("t2_addr", bus_addr_o, 32'h100);
        chk("t2_wdata", bus_wdata_o, 32'hDEAD_BEEF);
        slv_data = 32'h1111_2222;
        step();
        chk("t2_dack", 32'(d_ack_o), 32'd1);
        chk("t2_ifack_lo", 32'(if_ack_o), 32'd0);
        chk("t2_stall_if", 32'(stallreq_if_o), 32'd1);
        chk("t2_stall_mem", 32'(stallreq_mem_o), 32'd0);
        d_req_i = 1'b0;
        step();
        chk("t2_c3_stb", 32'(bus_stb_o), 32'd0);
        step();
        chk("t2_c4_stb", 32'(bus_stb_o), 32'd1);
        chk("t2_c4_addr", bus_addr_o, 32'h44);
        chk("t2_c4_sel", 32'(bus_sel_o), 32'hF);
        step();
        chk("t2_ifack", 32'(if_ack_o), 32'd1);
        chk("t2_ifrdata", if_rdata_o, 32'h1111_2222);
        if_req_i = 1'b0;
        step();

        // 3: wait states
        slv_wait = 3; slv_data = 32'h1234_5678;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200; d_sel_i = 4'hF;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("t3_stb", 32'(bus_stb_o & bus_cyc_o), 32'd1);
            chk("t3_addr", bus_addr_o, 32'h200);
            chk("t3_stall", 32'(stallreq_mem_o), 32'd1);
        end
        step();
        chk("t3_dack", 32'(d_ack_o), 32'd1);
        chk("t3_rdata", d_rdata_o, 32'h1234_5678);
        chk("t3_stall_ack", 32'(stallreq_mem_o), 32'd0);
        d_req_i = 1'b0;
        step();

        // 4: timeout
        slv_wait = 1000; slv_data = 32'h7777_7777;
        d_req_i = 1'b1; d_addr_i = 32'h300;
        for (int c = 1; c <= T; c++) begin
            step();
            chk("t4_stb", 32'(bus_stb_o), 32'd1);
            chk("t4_err_lo", 32'(bus_err_o), 32'd0);
        end
        step();
        chk("t4_stb_drop", 32'(bus_stb_o | bus_cyc_o), 32'd0);
        chk("t4_err", 32'(bus_err_o), 32'd1);
        chk("t4_dack", 32'(d_ack_o), 32'd1);
        chk("t4_rdata", d_rdata_o, 32'd0);
        d_req_i = 1'b0;
        step();
        chk("t4_err_pulse", 32'(bus_err_o), 32'd0);
        slv_wait = 0; slv_data = 32'hCAFE_0001;
        if_req_i = 1'b1; if_addr_i = 32'h50;
        step();
        chk("t4_next_stb", 32'(bus_stb_o), 32'd1);
        step();
        chk("t4_next_ack", 32'(if_ack_o), 32'd1);
        chk("t4_next_rdata", if_rdata_o, 32'hCAFE_0001);
        if_req_i = 1'b0;
        step();

        // 5: flush during IBUS wait
        slv_wait = 4; slv_data = 32'hBAD0_BAD0;
        if_req_i = 1'b1; if_addr_i = 32'h60;
        for (int c = 1; c <= 6; c++) begin
            step();
            flush_i = (c == 2);
            chk("t5_ifack_lo", 32'(if_ack_o), 32'd0);
        end
        chk("t5_stb_done", 32'(bus_stb_o), 32'd0);
        if_req_i = 1'b0;
        step();
        slv_wait = 0; slv_data = 32'h3C08_0001;
        if_req_i = 1'b1; if_addr_i = 32'h80;
        step();
        chk("t5_stb", 32'(bus_stb_o), 32'd1);
        chk("t5_addr", bus_addr_o, 32'h80);
        step();
        chk("t5_ack", 32'(if_ack_o), 32'd1);
        chk("t5_rdata", if_rdata_o, 32'h3C08_0001);
        if_req_i = 1'b0;
        step();

        // 6: reset mid-transaction, late ack ignored
        slv_wait = 1000;
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h400; d_wdata_i = 32'h5555_AAAA;
        d_sel_i = 4'hC;
        step();
        chk("t6_stb", 32'(bus_stb_o), 32'd1);
        rst = 1'b1;
        step();
        chk_reset_vals("t6");
        rst = 1'b0; d_req_i = 1'b0;
        slv_en = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t6_late_ack", {30'd0, d_ack_o, if_ack_o}, 32'd0);
            chk("t6_rdata", d_rdata_o, 32'd0);
        end
        bus_ack_i = 1'b0; slv_en = 1'b1; slv_cnt = 0;
        step();

        // Random transactions against the transaction-level model
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 2);
            q.delete();
            if (kind != 0) begin
                t.is_d = 1'b1; t.we = 1'($urandom_range(0, 1));
                t.addr = $urandom; t.wdata = $urandom; t.sel = 4'($urandom_range(1, 15));
                t.data = $urandom; t.w = $urandom_range(0, T + 2); t.fl = 1'b0;
                q.push_back(t);
                d_req_i = 1'b1; d_we_i = t.we; d_addr_i = t.addr; d_wdata_i = t.wdata;
                d_sel_i = t.sel;
            end
            if (kind != 1) begin
                t.is_d = 1'b0; t.we = 1'b0; t.addr = $urandom; t.wdata = '0; t.sel = 4'hF;
                t.data = $urandom; t.w = $urandom_range(0, T + 2);
                t.fl = (kind == 0) && ($urandom_range(0, 3) == 0);
                q.push_back(t);
                if_req_i = 1'b1; if_addr_i = t.addr;
            end
            for (int i = 0; i < q.size(); i++) begin
                t = q[i];
                slv_wait = t.w; slv_data = t.data;
                n = 0;
                while (!bus_stb_o && n < 6) begin
                    step();
                    n++;
                end
                chk("rnd_grant_gap", 32'(n), (i == 0) ? 32'd1 : 32'd2);
                chk("rnd_we", 32'(bus_we_o), 32'(t.we));
                chk("rnd_sel", 32'(bus_sel_o), 32'(t.sel));
                if (t.we) chk("rnd_wdata", bus_wdata_o, t.wdata);
                s = 0;
                while (bus_stb_o && s < 40) begin
                    chk("rnd_addr", bus_addr_o, t.addr);
                    chk("rnd_stall", 32'(t.is_d ? stallreq_mem_o : stallreq_if_o), 32'd1);
                    flush_i = t.fl && (s == 0);
                    s++;
                    step();
                end
                flush_i = 1'b0;
                exp_s  = (t.w <= T - 1) ? t.w + 1 : T;
                exp_rd = (t.w <= T - 1) ? t.data : 32'd0;
                chk("rnd_strobes", 32'(s), 32'(exp_s));
                chk("rnd_err", 32'(bus_err_o), 32'(t.w > T - 1));
                if (t.is_d) begin
                    chk("rnd_dack", {30'd0, d_ack_o, if_ack_o}, 32'd2);
                    chk("rnd_drdata", d_rdata_o, exp_rd);
                    d_req_i = 1'b0;
                end else begin
                    chk("rnd_ifack", {30'd0, d_ack_o, if_ack_o}, t.fl ? 32'd0 : 32'd1);
                    if (!t.fl) chk("rnd_ifrdata", if_rdata_o, exp_rd);
                    if_req_i = 1'b0;
                end
            end
            step();
            chk("rnd_idle", {29'd0, bus_stb_o, d_ack_o, if_ack_o}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
